// File: rtl/output_port_sw_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// output_port_sw_scheduler_pkg
// Shared definitions for the per-output-port switch scheduler:
//   - log2        : ceiling log2 helper (minimum result 1) for index/counter widths
//   - *_DEF       : default router sizing (ports, OVCs, downstream buffer depth)
//   - FULL_BIT / NFULL_BIT : bit positions inside each 2-bit ovc_status field
//   - credit_action_e      : what a credit counter does at the next edge
// ---------------------------------------------------------------------------
package output_port_sw_scheduler_pkg;

  localparam int PORT_NUM_DEF     = 5;
  localparam int VC_NUM_DEF       = 4;
  localparam int BUFFER_DEPTH_DEF = 4;

  localparam int FULL_BIT  = 1;
  localparam int NFULL_BIT = 0;

  typedef enum logic [1:0] {
    CR_HOLD = 2'd0,  // no change (idle, or consume and return together)
    CR_DEC  = 2'd1,  // flit sent downstream, no credit back
    CR_INC  = 2'd2,  // credit back, no flit sent
    CR_SAT  = 2'd3   // credit back while already at max: hold and flag error
  } credit_action_e;

  // Smallest width w >= 1 with 2**w >= value.
  function automatic int log2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        width = i + 1;
      end else begin
        width = width;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/output_port_sw_scheduler_if.sv
// ---------------------------------------------------------------------------
// output_port_sw_scheduler_if
// Bundle between the input-port side (master) and one output-port scheduler
// (slave).
//   req           : masked request per input port
//   req_ovc       : target OVC per requester, slice i = requester i
//   req_tail      : requested flit is a tail
//   credit_in     : one returned credit per OVC from downstream
//   grant         : registered one-hot grant
//   flit_wr_en    : granted flit crosses the switch this cycle
//   flit_ovc      : OVC of that flit
//   ovc_status    : per OVC {full, nearly_full}
//   ovc_available : OVC unowned and not full
//   credit_err    : sticky credit-overflow flag
// ---------------------------------------------------------------------------
interface output_port_sw_scheduler_if
  import output_port_sw_scheduler_pkg::*;
#(
  parameter int PORT_NUM = PORT_NUM_DEF,
  parameter int VC_NUM   = VC_NUM_DEF
);
  localparam int REQ_NUM  = PORT_NUM - 1;
  localparam int VC_BCD_W = log2(VC_NUM);

  logic [REQ_NUM-1:0]          req;
  logic [REQ_NUM*VC_BCD_W-1:0] req_ovc;
  logic [REQ_NUM-1:0]          req_tail;
  logic [VC_NUM-1:0]           credit_in;
  logic [REQ_NUM-1:0]          grant;
  logic                        flit_wr_en;
  logic [VC_BCD_W-1:0]         flit_ovc;
  logic [2*VC_NUM-1:0]         ovc_status;
  logic [VC_NUM-1:0]           ovc_available;
  logic                        credit_err;

  modport master (
    output req, req_ovc, req_tail, credit_in,
    input  grant, flit_wr_en, flit_ovc, ovc_status, ovc_available, credit_err
  );

  modport slave (
    input  req, req_ovc, req_tail, credit_in,
    output grant, flit_wr_en, flit_ovc, ovc_status, ovc_available, credit_err
  );

endinterface

// File: rtl/output_port_sw_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered priority pointer. The winner is the
// first asserted request at or after the pointer, wrapping N-1 -> 0. On a win
// the pointer moves to winner+1 (mod N); with no request it holds.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   req        : N request lines
//   grant      : combinational one-hot grant
//   any_grant  : some request won this cycle
// ---------------------------------------------------------------------------
module rr_arbiter
  import output_port_sw_scheduler_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         any_grant
);
  localparam int PTR_W = log2(N);
  localparam logic [PTR_W:0]   N_EXT  = (PTR_W + 1)'(N);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(32'd1);

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] ptr_next_s;
  logic [PTR_W-1:0] winner_s;
  logic [PTR_W-1:0] idx_s;
  logic [PTR_W:0]   sum_s;
  logic             found_s;
  logic [N-1:0]     grant_s;

  // Search from the pointer upward with wrap; first hit wins.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    idx_s    = '0;
    sum_s    = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr_r} + (PTR_W + 1)'(k);
      if (sum_s >= N_EXT) begin
        idx_s = PTR_W'(sum_s - N_EXT);
      end else begin
        idx_s = sum_s[PTR_W-1:0];
      end
      if (!found_s && req[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // One-hot decode of the winner.
  always_comb begin
    if (found_s) begin
      grant_s = {{(N-1){1'b0}}, 1'b1} << winner_s;
    end else begin
      grant_s = '0;
    end
  end

  // Pointer advances past the winner, holds when idle.
  always_comb begin
    if (!found_s) begin
      ptr_next_s = ptr_r;
    end else if (winner_s == PTR_LAST) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = winner_s + PTR_ONE;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_next_s;
    end
  end

  assign grant     = grant_s;
  assign any_grant = found_s;

endmodule

// File: rtl/output_port_sw_scheduler.sv
// ---------------------------------------------------------------------------
// output_port_sw_scheduler
// Switch scheduler of one router output port. Arbitrates round-robin among
// the masked requests of the PORT_NUM-1 input ports, tracks downstream
// credits and packet ownership per OVC, and reports OVC status/availability
// back to the input ports. All outputs are registered.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of output_port_sw_scheduler_if (req, req_ovc,
//                req_tail, credit_in in; grant, flit_wr_en, flit_ovc,
//                ovc_status, ovc_available, credit_err out)
// ---------------------------------------------------------------------------
module output_port_sw_scheduler
  import output_port_sw_scheduler_pkg::*;
#(
  parameter int PORT_NUM     = PORT_NUM_DEF,
  parameter int VC_NUM       = VC_NUM_DEF,
  parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF
) (
  input logic                         clk,
  input logic                         reset,
  output_port_sw_scheduler_if.slave   bus
);
  localparam int REQ_NUM  = PORT_NUM - 1;
  localparam int VC_BCD_W = log2(VC_NUM);
  localparam int CNT_W    = log2(BUFFER_DEPTH + 1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(BUFFER_DEPTH);
  localparam logic [CNT_W-1:0] CREDIT_ONE = CNT_W'(32'd1);

  logic [VC_NUM-1:0][CNT_W-1:0] credit_all_s;
  logic [REQ_NUM-1:0]           elig_s;
  logic [REQ_NUM-1:0]           win_onehot_s;
  logic                         any_s;
  logic [VC_BCD_W-1:0]          win_ovc_s;
  logic                         win_tail_s;
  logic [2*VC_NUM-1:0]          status_next_s;
  logic [VC_NUM-1:0]            available_next_s;
  logic [VC_NUM-1:0]            err_set_s;

  logic [REQ_NUM-1:0]           grant_r;
  logic                         flit_wr_en_r;
  logic [VC_BCD_W-1:0]          flit_ovc_r;
  logic [2*VC_NUM-1:0]          ovc_status_r;
  logic [VC_NUM-1:0]            ovc_available_r;
  logic                         credit_err_r;

  // Eligibility uses live counters; req_ovc of an idle port is never looked at.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (bus.req[i]) begin
        elig_s[i] = (credit_all_s[bus.req_ovc[i*VC_BCD_W +: VC_BCD_W]] != '0);
      end else begin
        elig_s[i] = 1'b0;
      end
    end
  end

  rr_arbiter #(.N(REQ_NUM)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (elig_s),
    .grant     (win_onehot_s),
    .any_grant (any_s)
  );

  // AND-OR mux of the winner's OVC and tail bit; non-winner slices are masked off.
  always_comb begin
    win_ovc_s  = '0;
    win_tail_s = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      win_ovc_s  = win_ovc_s  | ({VC_BCD_W{win_onehot_s[i]}} & bus.req_ovc[i*VC_BCD_W +: VC_BCD_W]);
      win_tail_s = win_tail_s | (win_onehot_s[i] & bus.req_tail[i]);
    end
  end

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    logic [CNT_W-1:0] credit_r;
    logic [CNT_W-1:0] credit_next_s;
    logic             owned_r;
    logic             owned_next_s;
    logic             consume_s;
    logic             ret_s;
    credit_action_e   action_s;

    assign consume_s = any_s & (win_ovc_s == VC_BCD_W'(v));
    assign ret_s     = bus.credit_in[v];

    // Classify this edge's credit movement.
    always_comb begin
      if (consume_s && !ret_s) begin
        action_s = CR_DEC;
      end else if (ret_s && !consume_s) begin
        if (credit_r == CREDIT_MAX) begin
          action_s = CR_SAT;
        end else begin
          action_s = CR_INC;
        end
      end else begin
        action_s = CR_HOLD;
      end
    end

    // Next credit value from the classified action.
    always_comb begin
      credit_next_s = credit_r;
      case (action_s)
        CR_DEC:  credit_next_s = credit_r - CREDIT_ONE;
        CR_INC:  credit_next_s = credit_r + CREDIT_ONE;
        CR_SAT:  credit_next_s = CREDIT_MAX;
        CR_HOLD: credit_next_s = credit_r;
        default: credit_next_s = credit_r;
      endcase
    end

    // A granted non-tail flit claims the OVC; a granted tail releases it.
    always_comb begin
      if (consume_s) begin
        owned_next_s = ~win_tail_s;
      end else begin
        owned_next_s = owned_r;
      end
    end

    // Per-OVC credit counter and ownership bit.
    always_ff @(posedge clk) begin
      if (reset) begin
        credit_r <= CREDIT_MAX;
        owned_r  <= 1'b0;
      end else begin
        credit_r <= credit_next_s;
        owned_r  <= owned_next_s;
      end
    end

    assign credit_all_s[v]                 = credit_r;
    assign err_set_s[v]                    = (action_s == CR_SAT);
    assign status_next_s[2*v + FULL_BIT]   = (credit_next_s == '0);
    assign status_next_s[2*v + NFULL_BIT]  = (credit_next_s == CREDIT_ONE);
    assign available_next_s[v]             = ~owned_next_s & (credit_next_s != '0);
  end

  // Output registers; status/available follow the next-state counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r         <= '0;
      flit_wr_en_r    <= 1'b0;
      flit_ovc_r      <= '0;
      ovc_status_r    <= '0;
      ovc_available_r <= '1;
      credit_err_r    <= 1'b0;
    end else begin
      grant_r         <= win_onehot_s;
      flit_wr_en_r    <= any_s;
      flit_ovc_r      <= win_ovc_s;
      ovc_status_r    <= status_next_s;
      ovc_available_r <= available_next_s;
      credit_err_r    <= credit_err_r | (|err_set_s);
    end
  end

  assign bus.grant         = grant_r;
  assign bus.flit_wr_en    = flit_wr_en_r;
  assign bus.flit_ovc      = flit_ovc_r;
  assign bus.ovc_status    = ovc_status_r;
  assign bus.ovc_available = ovc_available_r;
  assign bus.credit_err    = credit_err_r;

endmodule

// File: tb/tb_output_port_sw_scheduler.sv
// ---------------------------------------------------------------------------
// tb_output_port_sw_scheduler
// Directed bench for output_port_sw_scheduler (PORT_NUM=5, VC_NUM=4,
// BUFFER_DEPTH=4). Inputs change #1 after a rising edge; outputs are checked
// at the same point, i.e. they show the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_output_port_sw_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  output_port_sw_scheduler_if #(.PORT_NUM(5), .VC_NUM(4)) bus ();

  output_port_sw_scheduler #(.PORT_NUM(5), .VC_NUM(4), .BUFFER_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req       = 4'b0000;
    bus.req_ovc   = 8'h00;
    bus.req_tail  = 4'b0000;
    bus.credit_in = 4'b0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    cycle();
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b exp=%b", bus.grant, 4'b0000); end
    total++; if (bus.flit_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", bus.flit_wr_en); end
    total++; if (bus.flit_ovc !== 2'd0) begin bad++; $display("FAIL rst_flit_ovc got=%0d exp=0", bus.flit_ovc); end
    total++; if (bus.ovc_status !== 8'h00) begin bad++; $display("FAIL rst_status got=%b exp=%b", bus.ovc_status, 8'h00); end
    total++; if (bus.ovc_available !== 4'b1111) begin bad++; $display("FAIL rst_avail got=%b exp=1111", bus.ovc_available); end
    total++; if (bus.credit_err !== 1'b0) begin bad++; $display("FAIL rst_credit_err got=%b exp=0", bus.credit_err); end
    reset = 1'b0;
  endtask

  // All four requesters on OVC0: rotating grants drain credit 4 -> 0.
  task automatic test_drain();
    logic [3:0] exp_g [4];
    logic [1:0] exp_s [4];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_s = '{2'b00, 2'b00, 2'b01, 2'b10};
    bus.req = 4'b1111;
    bus.req_ovc = 8'h00;
    bus.req_tail = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      cycle();
      total++; if (bus.grant !== exp_g[c]) begin bad++; $display("FAIL drain_grant c=%0d got=%b exp=%b", c, bus.grant, exp_g[c]); end
      total++; if (bus.flit_wr_en !== 1'b1 || bus.flit_ovc !== 2'd0) begin bad++; $display("FAIL drain_flit c=%0d got=%b/%0d exp=1/0", c, bus.flit_wr_en, bus.flit_ovc); end
      total++; if (bus.ovc_status[1:0] !== exp_s[c]) begin bad++; $display("FAIL drain_status c=%0d got=%b exp=%b", c, bus.ovc_status[1:0], exp_s[c]); end
    end
    cycle();
    total++; if (bus.grant !== 4'b0000 || bus.flit_wr_en !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b/%b exp=0000/0", bus.grant, bus.flit_wr_en); end
    total++; if (bus.ovc_available !== 4'b1110) begin bad++; $display("FAIL drain_avail got=%b exp=1110", bus.ovc_available); end
  endtask

  // Credit comes back at zero: not granted that edge, granted the next.
  task automatic test_credit_return();
    bus.credit_in = 4'b0001;
    cycle();
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL cret_no_grant got=%b exp=0000", bus.grant); end
    total++; if (bus.ovc_status[1:0] !== 2'b01) begin bad++; $display("FAIL cret_status1 got=%b exp=01", bus.ovc_status[1:0]); end
    bus.credit_in = 4'b0000;
    cycle();
    total++; if (bus.grant !== 4'b0001 || bus.flit_wr_en !== 1'b1) begin bad++; $display("FAIL cret_grant got=%b/%b exp=0001/1", bus.grant, bus.flit_wr_en); end
    total++; if (bus.ovc_status[1:0] !== 2'b10) begin bad++; $display("FAIL cret_status2 got=%b exp=10", bus.ovc_status[1:0]); end
  endtask

  // Consume+return in one edge holds; return at max saturates and flags.
  task automatic test_credit_edge();
    bus.req = 4'b0000;
    bus.credit_in = 4'b0001;
    cycle();
    bus.req = 4'b0010;
    bus.req_tail = 4'b0010;
    cycle();
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL cedge_grant got=%b exp=0010", bus.grant); end
    total++; if (bus.ovc_status[1:0] !== 2'b01) begin bad++; $display("FAIL cedge_hold got=%b exp=01", bus.ovc_status[1:0]); end
    total++; if (bus.ovc_available[0] !== 1'b1) begin bad++; $display("FAIL cedge_avail got=%b exp=1", bus.ovc_available[0]); end
    bus.req = 4'b0000;
    bus.req_tail = 4'b0000;
    for (int c = 0; c < 3; c++) cycle();
    total++; if (bus.ovc_status[1:0] !== 2'b00 || bus.credit_err !== 1'b0) begin bad++; $display("FAIL cedge_full_credit got=%b/%b exp=00/0", bus.ovc_status[1:0], bus.credit_err); end
    cycle();
    total++; if (bus.credit_err !== 1'b1) begin bad++; $display("FAIL cedge_err got=%b exp=1", bus.credit_err); end
    total++; if (bus.ovc_status !== 8'h00 || bus.ovc_available !== 4'b1111) begin bad++; $display("FAIL cedge_sat got=%b/%b exp=00000000/1111", bus.ovc_status, bus.ovc_available); end
    bus.credit_in = 4'b0000;
    cycle();
    total++; if (bus.credit_err !== 1'b1) begin bad++; $display("FAIL cedge_sticky got=%b exp=1", bus.credit_err); end
  endtask

  // Head claims OVC2, tail frees it, single-flit packet never claims OVC3.
  task automatic test_ownership();
    test_reset();
    bus.req = 4'b0100;
    bus.req_ovc = 8'b00_10_00_00;
    bus.req_tail = 4'b0000;
    cycle();
    total++; if (bus.grant !== 4'b0100 || bus.flit_ovc !== 2'd2) begin bad++; $display("FAIL own_head got=%b/%0d exp=0100/2", bus.grant, bus.flit_ovc); end
    total++; if (bus.ovc_available !== 4'b1011) begin bad++; $display("FAIL own_claim got=%b exp=1011", bus.ovc_available); end
    bus.req = 4'b0000;
    cycle();
    total++; if (bus.ovc_available !== 4'b1011) begin bad++; $display("FAIL own_keep got=%b exp=1011", bus.ovc_available); end
    bus.req = 4'b0100;
    bus.req_tail = 4'b0100;
    cycle();
    total++; if (bus.ovc_available !== 4'b1111) begin bad++; $display("FAIL own_release got=%b exp=1111", bus.ovc_available); end
    bus.req = 4'b0010;
    bus.req_ovc = 8'b00_00_11_00;
    bus.req_tail = 4'b0010;
    cycle();
    total++; if (bus.grant !== 4'b0010 || bus.flit_ovc !== 2'd3) begin bad++; $display("FAIL own_single_grant got=%b/%0d exp=0010/3", bus.grant, bus.flit_ovc); end
    total++; if (bus.ovc_available !== 4'b1111) begin bad++; $display("FAIL own_single got=%b exp=1111", bus.ovc_available); end
  endtask

  // Pointer wraps 3 -> 0 and holds across an idle cycle.
  task automatic test_pointer_wrap();
    test_reset();
    bus.req = 4'b0100;
    bus.req_ovc = 8'b00_01_00_00;
    bus.req_tail = 4'b1111;
    cycle();
    total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL wrap_setup got=%b exp=0100", bus.grant); end
    bus.req = 4'b1001;
    bus.req_ovc = 8'b01_xx_xx_01;
    cycle();
    total++; if (bus.grant !== 4'b1000) begin bad++; $display("FAIL wrap_first got=%b exp=1000", bus.grant); end
    cycle();
    total++; if (bus.grant !== 4'b0001 || bus.flit_ovc !== 2'd1) begin bad++; $display("FAIL wrap_second got=%b/%0d exp=0001/1", bus.grant, bus.flit_ovc); end
    bus.req = 4'b0000;
    cycle();
    total++; if (bus.grant !== 4'b0000 || bus.flit_wr_en !== 1'b0) begin bad++; $display("FAIL wrap_idle got=%b/%b exp=0000/0", bus.grant, bus.flit_wr_en); end
    bus.req = 4'b1001;
    cycle();
    total++; if (bus.grant !== 4'b1000) begin bad++; $display("FAIL wrap_hold got=%b exp=1000", bus.grant); end
    total++; if (bus.ovc_status[3:2] !== 2'b10) begin bad++; $display("FAIL wrap_ovc1_full got=%b exp=10", bus.ovc_status[3:2]); end
  endtask

  // Reset while OVC1 is owned with one credit left.
  task automatic test_reset_midpacket();
    logic [1:0] exp_s [3];
    exp_s = '{2'b00, 2'b00, 2'b01};
    test_reset();
    bus.req = 4'b0010;
    bus.req_ovc = 8'b00_00_01_00;
    bus.req_tail = 4'b0000;
    for (int c = 0; c < 3; c++) cycle();
    total++; if (bus.ovc_status[3:2] !== 2'b01 || bus.ovc_available[1] !== 1'b0) begin bad++; $display("FAIL mid_setup got=%b/%b exp=01/0", bus.ovc_status[3:2], bus.ovc_available[1]); end
    reset = 1'b1;
    cycle();
    total++; if (bus.grant !== 4'b0000 || bus.flit_wr_en !== 1'b0 || bus.flit_ovc !== 2'd0) begin bad++; $display("FAIL mid_rst_grant got=%b/%b/%0d exp=0000/0/0", bus.grant, bus.flit_wr_en, bus.flit_ovc); end
    total++; if (bus.ovc_status !== 8'h00 || bus.ovc_available !== 4'b1111) begin bad++; $display("FAIL mid_rst_status got=%b/%b exp=00000000/1111", bus.ovc_status, bus.ovc_available); end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      total++; if (bus.ovc_status[3:2] !== exp_s[c]) begin bad++; $display("FAIL mid_refill c=%0d got=%b exp=%b", c, bus.ovc_status[3:2], exp_s[c]); end
    end
    total++; if (bus.ovc_available[1] !== 1'b0) begin bad++; $display("FAIL mid_reown got=%b exp=0", bus.ovc_available[1]); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_credit_return();
    test_credit_edge();
    test_ownership();
    test_pointer_wrap();
    test_reset_midpacket();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
